// File: rtl/llc_trace_sequencer_pkg.sv
// Shared types for the LLC trace sequencer: trace opcodes,
// sequencer FSM states and the buffered command record.
package LLC_defs;

   localparam int SEQ_FIFO_DEPTH = 4;
   localparam int CMD_W          = 37;

   typedef enum logic [3:0] {
      RD_L1D   = 4'd0,
      WR_L1D   = 4'd1,
      RD_L1I   = 4'd2,
      SNP_RD   = 4'd3,
      SNP_WR   = 4'd4,
      SNP_RWIM = 4'd5,
      SNP_INV  = 4'd6,
      CLEAR    = 4'd8,
      PRINT    = 4'd9
   } trace_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PRINT,
      S_FINISH
   } seq_state_e;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic        last;
   } seq_cmd_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= 4'd6) || (op == 4'd8) || (op == 4'd9);
   endfunction

endpackage

// File: rtl/llc_trace_sequencer_cmd_fifo.sv
// Command buffer: synchronous FIFO of {op, addr, last} with
// an occupancy counter driving the full/empty flags.
module llc_cmd_fifo
   import LLC_defs::*;
#(
   parameter int DEPTH = SEQ_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] wdata,
   output logic [CMD_W-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             wr;
   logic             rd;

   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/llc_trace_sequencer.sv
// Trace sequencer: buffers trace commands, filters illegal
// opcodes and paces issue / dump requests to the LLC stage.
module llc_trace_sequencer
   import LLC_defs::*;
#(
   parameter int FIFO_DEPTH = SEQ_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic        in_last,
   output logic        llc_valid,
   output logic [3:0]  llc_op,
   output logic [31:0] llc_addr,
   input  logic        llc_busy,
   output logic        print_req,
   input  logic        print_ack,
   output logic        done,
   output logic [31:0] cmd_count,
   output logic [15:0] drop_count
);

   seq_state_e state_q, state_d;
   seq_cmd_t   wcmd, head;
   logic       full, empty;
   logic       accept, legal, push, pop;
   logic       last_q, pend_q;

   assign in_ready  = reset && !full;
   assign accept    = in_valid && in_ready;
   assign legal     = op_legal(in_op);
   assign push      = accept && legal;
   assign wcmd      = '{op: in_op, addr: in_addr, last: in_last};
   assign llc_valid = (state_q == S_ISSUE);
   assign print_req = (state_q == S_PRINT);

   llc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wcmd),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE, S_FINISH: begin
            if (!empty) begin
               if (head.op == PRINT) state_d = S_PRINT;
               else if (!llc_busy)   state_d = S_ISSUE;
            end else if (pend_q) begin
               state_d = S_FINISH;
            end
         end
         S_ISSUE: begin
            pop     = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!llc_busy) state_d = last_q ? S_FINISH : S_IDLE;
         end
         S_PRINT: begin
            if (print_ack) begin
               pop     = 1'b1;
               state_d = head.last ? S_FINISH : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         llc_op     <= '0;
         llc_addr   <= '0;
         last_q     <= 1'b0;
         pend_q     <= 1'b0;
         done       <= 1'b0;
         cmd_count  <= '0;
         drop_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_ISSUE) begin
            llc_op   <= head.op;
            llc_addr <= head.addr;
         end
         if (state_q == S_ISSUE) begin
            last_q    <= head.last;
            cmd_count <= cmd_count + 1'b1;
         end
         // a dropped last marker finishes the trace once the queue drains
         if (accept && !legal) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            if (in_last) pend_q <= 1'b1;
         end else if (state_d == S_FINISH) begin
            pend_q <= 1'b0;
         end
         if (state_d == S_FINISH) done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_llc_trace_sequencer.sv
// Directed bench for llc_trace_sequencer: hand-computed vectors
// checked with immediate assertions on the falling edge.
module tb_llc_trace_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_addr;
   logic        in_last;
   logic        llc_valid;
   logic [3:0]  llc_op;
   logic [31:0] llc_addr;
   logic        llc_busy;
   logic        print_req;
   logic        print_ack;
   logic        done;
   logic [31:0] cmd_count;
   logic [15:0] drop_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   llc_trace_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_addr    (in_addr),
      .in_last    (in_last),
      .llc_valid  (llc_valid),
      .llc_op     (llc_op),
      .llc_addr   (llc_addr),
      .llc_busy   (llc_busy),
      .print_req  (print_req),
      .print_ack  (print_ack),
      .done       (done),
      .cmd_count  (cmd_count),
      .drop_count (drop_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
   endtask

   // single push, returns on the negedge after the accepting edge
   task automatic push(input logic [3:0] op, input logic [31:0] addr,
                       input logic last);
      int n;
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("push_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   logic [3:0]  got_op [5];
   logic [31:0] got_addr [5];
   int          got_cyc [5];
   int          nissued;
   logic        accept_now;
   logic        saw_valid;
   logic        done_low;

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_addr   = '0;
      in_last   = 1'b0;
      llc_busy  = 1'b0;
      print_ack = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_llc_valid", {31'd0, llc_valid}, 32'd0);
      chk("rst_llc_op", {28'd0, llc_op}, 32'd0);
      chk("rst_llc_addr", llc_addr, 32'd0);
      chk("rst_print_req", {31'd0, print_req}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cmd_count", cmd_count, 32'd0);
      chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // single issue
      push(4'd0, 32'h1000_0040, 1'b0);
      chk("t1_no_valid_yet", {31'd0, llc_valid}, 32'd0);
      tick();
      chk("t1_valid", {31'd0, llc_valid}, 32'd1);
      chk("t1_op", {28'd0, llc_op}, 32'd0);
      chk("t1_addr", llc_addr, 32'h1000_0040);
      tick();
      chk("t1_valid_one_cycle", {31'd0, llc_valid}, 32'd0);
      chk("t1_cmd_count", cmd_count, 32'd1);
      chk("t1_addr_hold", llc_addr, 32'h1000_0040);
      tick();
      tick();

      // burst of five while the cache is busy
      llc_busy = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_op   = 4'(i + 1);
         in_addr = 32'h3000_0000 + 32'(i * 4);
         chk("t2_ready", {31'd0, in_ready}, 32'd1);
         @(negedge clk);
      end
      in_op   = 4'd5;
      in_addr = 32'h3000_0010;
      chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t2_held_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_busy_no_issue", {31'd0, llc_valid}, 32'd0);
      llc_busy = 1'b0;
      nissued  = 0;
      for (int c = 0; c < 40; c++) begin
         if (llc_valid) begin
            if (nissued < 5) begin
               got_op[nissued]   = llc_op;
               got_addr[nissued] = llc_addr;
               got_cyc[nissued]  = c;
            end
            nissued++;
         end
         accept_now = in_valid && in_ready;
         @(negedge clk);
         if (accept_now) in_valid = 1'b0;
      end
      chk("t2_num_issued", nissued, 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk("t2_op", {28'd0, got_op[k]}, 32'(k + 1));
         chk("t2_addr", got_addr[k], 32'h3000_0000 + 32'(k * 4));
         if (k > 0)
            chk("t2_spacing_ge3",
                {31'd0, (got_cyc[k] - got_cyc[k-1]) >= 3}, 32'd1);
      end
      chk("t2_cmd_count", cmd_count, 32'd6);

      // illegal opcodes
      do_reset();
      saw_valid = 1'b0;
      push(4'd7, 32'h0000_0100, 1'b0);
      push(4'd12, 32'h0000_0200, 1'b0);
      for (int c = 0; c < 6; c++) begin
         if (llc_valid) saw_valid = 1'b1;
         tick();
      end
      chk("t3_drop_count", {16'd0, drop_count}, 32'd2);
      chk("t3_no_valid", {31'd0, saw_valid}, 32'd0);
      chk("t3_cmd_count", cmd_count, 32'd0);
      chk("t3_ready", {31'd0, in_ready}, 32'd1);
      chk("t3_done", {31'd0, done}, 32'd0);

      // print with delayed ack, then a write behind it
      do_reset();
      push(4'd9, 32'h0000_0000, 1'b0);
      push(4'd1, 32'h2000_0000, 1'b0);
      chk("t4_req_1", {31'd0, print_req}, 32'd1);
      chk("t4_no_valid_1", {31'd0, llc_valid}, 32'd0);
      for (int c = 2; c <= 6; c++) begin
         tick();
         chk("t4_req_held", {31'd0, print_req}, 32'd1);
         chk("t4_no_valid", {31'd0, llc_valid}, 32'd0);
      end
      print_ack = 1'b1;
      tick();
      print_ack = 1'b0;
      chk("t4_req_drop", {31'd0, print_req}, 32'd0);
      chk("t4_valid_after_ack_0", {31'd0, llc_valid}, 32'd0);
      tick();
      chk("t4_valid", {31'd0, llc_valid}, 32'd1);
      chk("t4_op", {28'd0, llc_op}, 32'd1);
      chk("t4_addr", llc_addr, 32'h2000_0000);
      tick();
      chk("t4_cmd_count", cmd_count, 32'd1);

      // last command sets sticky done
      do_reset();
      push(4'd3, 32'h0000_000A, 1'b1);
      chk("t5_done_0a", {31'd0, done}, 32'd0);
      tick();
      chk("t5_issue", {31'd0, llc_valid}, 32'd1);
      tick();
      chk("t5_done_0b", {31'd0, done}, 32'd0);
      tick();
      chk("t5_done_1", {31'd0, done}, 32'd1);
      done_low = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (!done) done_low = 1'b1;
         tick();
      end
      chk("t5_done_sticky", {31'd0, done_low}, 32'd0);
      push(4'd2, 32'h0000_000B, 1'b0);
      tick();
      chk("t5_finish_issues", {31'd0, llc_valid}, 32'd1);
      chk("t5_finish_addr", llc_addr, 32'h0000_000B);
      tick();
      tick();
      chk("t5_done_kept", {31'd0, done}, 32'd1);

      // dropped last marker still finishes the trace
      do_reset();
      push(4'd7, 32'h0000_0000, 1'b1);
      chk("t6_done_0", {31'd0, done}, 32'd0);
      tick();
      chk("t6_done_1", {31'd0, done}, 32'd1);
      chk("t6_cmd_count", cmd_count, 32'd0);

      // reset during issue with entries queued
      do_reset();
      llc_busy = 1'b1;
      push(4'd0, 32'h0000_1000, 1'b0);
      push(4'd1, 32'h0000_2000, 1'b0);
      push(4'd2, 32'h0000_3000, 1'b0);
      llc_busy = 1'b0;
      tick();
      chk("t7_issue", {31'd0, llc_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t7_async_valid", {31'd0, llc_valid}, 32'd0);
      chk("t7_async_op", {28'd0, llc_op}, 32'd0);
      chk("t7_async_addr", llc_addr, 32'd0);
      chk("t7_async_ready", {31'd0, in_ready}, 32'd0);
      chk("t7_async_count", cmd_count, 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      saw_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (llc_valid) saw_valid = 1'b1;
      end
      chk("t7_no_valid_after", {31'd0, saw_valid}, 32'd0);
      chk("t7_ready_after", {31'd0, in_ready}, 32'd1);
      push(4'd4, 32'h0000_4000, 1'b0);
      tick();
      chk("t7_new_issue", {31'd0, llc_valid}, 32'd1);
      chk("t7_new_addr", llc_addr, 32'h0000_4000);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
